traffic_conflict_monitor: RTL and testbench
===========================================

# traffic_conflict_monitor

Fail-safe stage directly downstream of `Traffic_light_control`. It consumes the four 3-bit lamp vectors (M1, M2, MT, S) and passes them to the lamp drivers with one cycle of latency. It checks every cycle for illegal codes, conflicting right-of-way, illegal sequencing and dwell violations. On any violation it latches a fault and forces all approaches to flashing red until cleared.

## Interface
- `MIN_YELLOW`, 2: minimum consecutive yellow cycles before red.
- `MAX_GREEN`, 60: maximum consecutive green cycles on any approach.
- `FLASH_HALF`, 1: cycles per on-phase and per off-phase of fault flashing.
- `STARTUP`, 3: cycles of forced all-red after reset or after a fault clear.
- All parameters are in the range 1..255 (8-bit counters).
- `clk` in 1: system clock, 1 cycle = 1 s.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `light_M1`, `light_M2`, `light_MT`, `light_S` in 3 each: lamp vectors from the controller. Red=100, yellow=010, green=001.
- `fault_clr` in 1: fault acknowledge, level-sampled.
- `safe_M1`, `safe_M2`, `safe_MT`, `safe_S` out 3 each: registered lamp-driver vectors.
- `fault` out 1: latched fault flag.
- `fault_code` out 3: 0 = none, 1 = illegal code, 2 = conflict, 3 = illegal transition, 4 = short yellow, 5 = overlong green.
- `fault_src` out 4: one-hot offending approach(es). Bit 0 = M1, 1 = M2, 2 = MT, 3 = S.

## Operation
- **States:** INIT, RUN, FAULT. Reset enters INIT.
- **INIT:** all `safe_*` = 100. A startup counter counts STARTUP cycles, then the block enters RUN.
- **RUN:** each `safe_*` <= the matching `light_*` (registered), unless a check fails on that cycle.
- **Check timing:** all checks are combinational on the current inputs plus the per-approach history registers. Checks are evaluated only in RUN.
- **Illegal code:** any input not in {100, 010, 001}.
- **Conflict:** two approaches of a conflicting pair are both non-red. Conflicting pairs are (M1,S), (M2,S), (MT,S), (M2,MT). M1 with M2 and M1 with MT are compatible.
- **Transition:** the legal changes are red->green, green->yellow and yellow->red. Holding the same value is also legal. Any other change is a fault. The previous-value register updates every cycle in every state.
- **Dwell counters:** one 8-bit counter per approach. It resets to 1 when the value changes and increments while the value holds, saturating at 255. It runs in all states, from reset value 0.
- **Short yellow:** a yellow->red change is a fault when the yellow dwell count is below MIN_YELLOW.
- **Overlong green:** a fault when green is held and the dwell count reaches MAX_GREEN+1.
- **Fault priority:** when several checks fire in one cycle, the lowest code wins. `fault_src` marks only the approaches involved in the winning code.
- **On fault detection:** `fault` = 1, and `fault_code`/`fault_src` latch. The state goes to FAULT on the same edge.
  - The faulty input pattern is never driven on `safe_*`; that edge loads 100 on all approaches.
- **FAULT:** all `safe_*` alternate 100 for FLASH_HALF cycles and 000 for FLASH_HALF cycles. The on-phase starts with the first FAULT cycle. No further code latches.
- **Fault clear:** `fault_clr` = 1 while all four inputs = 100 moves the block to INIT. The clear also zeroes `fault`, `fault_code` and `fault_src`, and restarts the startup count. `fault_clr` in any other condition or state is ignored.
- **Reset mid-operation:** `rst` overrides everything, including FAULT. It returns to INIT with all outputs at reset values.

## Timing
- **Reset values:** `safe_*` = 100, `fault` = 0, `fault_code` = 000, `fault_src` = 0000. State = INIT, all counters 0.
- **After `rst` deassert:** INIT holds for exactly STARTUP cycles. The first pass-through value appears on edge STARTUP+1.
- **RUN latency:** input at edge N appears on `safe_*` after edge N.
- **Fault latency:** violating input sampled at edge N gives `fault`/`fault_code` = 1/code after edge N, with `safe_*` = 100.
- **Flash period:** 2*FLASH_HALF cycles, free-running from FAULT entry.
- **Clear latency:** clear sampled at edge N puts the block in INIT after edge N. RUN follows STARTUP cycles later.

## Test plan
- **Reset/startup:** pulse `rst` for 1 cycle with inputs M1=001, M2=001, MT=100, S=100.
  - `safe_*` = 100 for 3 cycles, then `safe_M1` = `safe_M2` = 001, `fault` = 0.
- **Normal cycle:** drive a legal sequence M1/M2 green 10, M2 yellow 2, M1+MT green 5, yellow 2, S green 5, yellow 2.
  - `safe_*` mirrors the inputs delayed by 1 cycle, and `fault` stays 0 throughout.
- **Conflict:** in RUN, drive MT=001 and M2=001 together.
  - Next edge: `fault` = 1, `fault_code` = 2, `fault_src` = 0110, `safe_*` = 100.
  - After that, `safe_*` alternates 100/000 every cycle.
- **Sequencing:** drive M1 green->red directly, giving code 3 with src 0001.
  - After reset, drive S yellow for 1 cycle then red, giving code 4 with src 1000.
- **Overlong green plus simultaneous faults:** hold M1=001 for 61 cycles, giving code 5.
  - Separately, drive S=011 together with a conflict. Code 1 wins and `fault_src` = 1000.
- **Clear and reset in FAULT:** assert `fault_clr` while S is still green, and confirm it is ignored.
  - Then assert `fault_clr` with all inputs red: `fault` = 0 next edge, then INIT lasts 3 cycles.
  - Assert `rst` during flashing: all outputs return to reset values next edge.

Source files
------------

// File: rtl/traffic_conflict_monitor.sv
// Fail-safe lamp stage: registers controller lamp vectors to the drivers and latches a
// flashing-red fault on illegal codes, right-of-way conflicts, bad sequencing or dwell errors.
module traffic_conflict_monitor #(
    parameter int unsigned MIN_YELLOW = 2,
    parameter int unsigned MAX_GREEN  = 60,
    parameter int unsigned FLASH_HALF = 1,
    parameter int unsigned STARTUP    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_S,
    input  logic       fault_clr,
    output logic [2:0] safe_M1,
    output logic [2:0] safe_M2,
    output logic [2:0] safe_MT,
    output logic [2:0] safe_S,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [3:0] fault_src
);

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] DARK   = 3'b000;

    localparam logic [7:0] MIN_YELLOW_C = 8'(MIN_YELLOW);
    localparam logic [7:0] MAX_GREEN_C  = 8'(MAX_GREEN);
    localparam logic [7:0] FLASH_LAST   = 8'(FLASH_HALF - 1);
    localparam logic [7:0] STARTUP_LAST = 8'(STARTUP - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_FAULT
    } state_t;

    typedef enum logic [2:0] {
        FC_NONE         = 3'd0,
        FC_ILLEGAL      = 3'd1,
        FC_CONFLICT     = 3'd2,
        FC_TRANSITION   = 3'd3,
        FC_SHORT_YELLOW = 3'd4,
        FC_LONG_GREEN   = 3'd5
    } fault_code_t;

    // Approach index order: 0 = M1, 1 = M2, 2 = MT, 3 = S (matches fault_src bits).
    logic [2:0] light_w [4];
    assign light_w[0] = light_M1;
    assign light_w[1] = light_M2;
    assign light_w[2] = light_MT;
    assign light_w[3] = light_S;

    logic all_red;
    assign all_red = (light_M1 == RED) && (light_M2 == RED) &&
                     (light_MT == RED) && (light_S == RED);

    logic [2:0]  prev_q  [4];
    logic [7:0]  dwell_q [4];
    logic [7:0]  dwell_d [4];

    state_t      state_q, state_d;
    logic [7:0]  startup_q, startup_d;
    logic [7:0]  flash_cnt_q, flash_cnt_d;
    logic        flash_on_q, flash_on_d;
    logic [2:0]  safe_q [4];
    logic [2:0]  safe_d [4];
    logic        fault_q, fault_d;
    fault_code_t code_q, code_d;
    logic [3:0]  src_q, src_d;

    fault_code_t det_code;
    logic [3:0]  det_src;
    logic [3:0]  nonred, illegal_src, conflict_src, trans_src, short_src, long_src;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dwell_d[i] = dwell_q[i];
            if (light_w[i] != prev_q[i]) begin
                dwell_d[i] = 8'd1;
            end else if (dwell_q[i] != 8'hFF) begin
                dwell_d[i] = dwell_q[i] + 8'd1;
            end
        end
    end

    always_comb begin
        nonred       = '0;
        illegal_src  = '0;
        conflict_src = '0;
        trans_src    = '0;
        short_src    = '0;
        long_src     = '0;
        for (int i = 0; i < 4; i++) begin
            nonred[i]      = (light_w[i] != RED);
            illegal_src[i] = !(light_w[i] inside {RED, YELLOW, GREEN});
            trans_src[i]   = !((light_w[i] == prev_q[i]) ||
                               (prev_q[i] == RED    && light_w[i] == GREEN)  ||
                               (prev_q[i] == GREEN  && light_w[i] == YELLOW) ||
                               (prev_q[i] == YELLOW && light_w[i] == RED));
            short_src[i]   = (prev_q[i] == YELLOW) && (light_w[i] == RED) &&
                             (dwell_q[i] < MIN_YELLOW_C);
            // Held green whose next count would pass MAX_GREEN.
            long_src[i]    = (prev_q[i] == GREEN) && (light_w[i] == GREEN) &&
                             (dwell_q[i] >= MAX_GREEN_C);
        end
        if (nonred[0] && nonred[3]) conflict_src = conflict_src | 4'b1001;
        if (nonred[1] && nonred[3]) conflict_src = conflict_src | 4'b1010;
        if (nonred[2] && nonred[3]) conflict_src = conflict_src | 4'b1100;
        if (nonred[1] && nonred[2]) conflict_src = conflict_src | 4'b0110;

        det_code = FC_NONE;
        det_src  = '0;
        if (|illegal_src) begin
            det_code = FC_ILLEGAL;
            det_src  = illegal_src;
        end else if (|conflict_src) begin
            det_code = FC_CONFLICT;
            det_src  = conflict_src;
        end else if (|trans_src) begin
            det_code = FC_TRANSITION;
            det_src  = trans_src;
        end else if (|short_src) begin
            det_code = FC_SHORT_YELLOW;
            det_src  = short_src;
        end else if (|long_src) begin
            det_code = FC_LONG_GREEN;
            det_src  = long_src;
        end
    end

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        startup_d   = startup_q;
        flash_cnt_d = flash_cnt_q;
        flash_on_d  = flash_on_q;
        fault_d     = fault_q;
        code_d      = code_q;
        src_d       = src_q;
        for (int i = 0; i < 4; i++) safe_d[i] = RED;

        case (state_q)
            ST_INIT: begin
                if (startup_q == STARTUP_LAST) begin
                    state_d   = ST_RUN;
                    startup_d = '0;
                end else begin
                    startup_d = startup_q + 8'd1;
                end
            end
            ST_RUN: begin
                if (det_code != FC_NONE) begin
                    state_d     = ST_FAULT;
                    fault_d     = 1'b1;
                    code_d      = det_code;
                    src_d       = det_src;
                    flash_cnt_d = '0;
                    flash_on_d  = 1'b1;
                end else begin
                    for (int i = 0; i < 4; i++) safe_d[i] = light_w[i];
                end
            end
            ST_FAULT: begin
                if (fault_clr && all_red) begin
                    state_d   = ST_INIT;
                    startup_d = '0;
                    fault_d   = 1'b0;
                    code_d    = FC_NONE;
                    src_d     = '0;
                end else begin
                    if (flash_cnt_q == FLASH_LAST) begin
                        flash_cnt_d = '0;
                        flash_on_d  = !flash_on_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q + 8'd1;
                    end
                    for (int i = 0; i < 4; i++) safe_d[i] = flash_on_d ? RED : DARK;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            startup_q   <= '0;
            flash_cnt_q <= '0;
            flash_on_q  <= 1'b0;
            fault_q     <= 1'b0;
            code_q      <= FC_NONE;
            src_q       <= '0;
            // NOTE: the small history arrays are reset explicitly; they feed the checks directly.
            for (int i = 0; i < 4; i++) begin
                safe_q[i]  <= RED;
                prev_q[i]  <= RED;
                dwell_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            startup_q   <= startup_d;
            flash_cnt_q <= flash_cnt_d;
            flash_on_q  <= flash_on_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
            src_q       <= src_d;
            for (int i = 0; i < 4; i++) begin
                safe_q[i]  <= safe_d[i];
                prev_q[i]  <= light_w[i];
                dwell_q[i] <= dwell_d[i];
            end
        end
    end

    assign safe_M1    = safe_q[0];
    assign safe_M2    = safe_q[1];
    assign safe_MT    = safe_q[2];
    assign safe_S     = safe_q[3];
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign fault_src  = src_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor: startup, pass-through, every fault class,
// priority, flashing, clear and reset-in-fault, with hand-computed expectations.
module tb_traffic_conflict_monitor;

    localparam logic [2:0]  RED = 3'b100;
    localparam logic [2:0]  YEL = 3'b010;
    localparam logic [2:0]  GRN = 3'b001;
    localparam logic [2:0]  OFF = 3'b000;
    localparam logic [11:0] ALL_RED = {RED, RED, RED, RED};
    localparam logic [11:0] ALL_OFF = {OFF, OFF, OFF, OFF};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fault_clr = 1'b0;
    logic [2:0] light_M1 = RED, light_M2 = RED, light_MT = RED, light_S = RED;
    logic [2:0] safe_M1, safe_M2, safe_MT, safe_S;
    logic       fault;
    logic [2:0] fault_code;
    logic [3:0] fault_src;
    logic [11:0] safe_bus;

    int total = 0;
    int bad   = 0;

    assign safe_bus = {safe_M1, safe_M2, safe_MT, safe_S};

    traffic_conflict_monitor #(
        .MIN_YELLOW(2), .MAX_GREEN(60), .FLASH_HALF(1), .STARTUP(3)
    ) dut (
        .clk(clk), .rst(rst),
        .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT), .light_S(light_S),
        .fault_clr(fault_clr),
        .safe_M1(safe_M1), .safe_M2(safe_M2), .safe_MT(safe_MT), .safe_S(safe_S),
        .fault(fault), .fault_code(fault_code), .fault_src(fault_src)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [11:0] pat);
        {light_M1, light_M2, light_MT, light_S} = pat;
    endtask

    // Reset with all inputs red and wait out INIT; the next edge is the first RUN edge.
    task automatic startup();
        drive(ALL_RED);
        fault_clr = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        drive({GRN, GRN, RED, RED});
        rst = 1'b1;
        tick();
        total++;
        if (safe_bus !== ALL_RED || fault !== 1'b0 || fault_code !== 3'd0 || fault_src !== 4'd0) begin
            bad++;
            $display("FAIL reset_values: safe=%h fault=%b code=%0d src=%b, want safe=%h 0 0 0000",
                     safe_bus, fault, fault_code, fault_src, ALL_RED);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (safe_bus !== ALL_RED) begin
                bad++;
                $display("FAIL startup_hold[%0d]: safe=%h want %h", i, safe_bus, ALL_RED);
            end
        end
        tick();
        total++;
        if (safe_bus !== {GRN, GRN, RED, RED} || fault !== 1'b0) begin
            bad++;
            $display("FAIL first_pass: safe=%h fault=%b want %h 0", safe_bus, fault, {GRN, GRN, RED, RED});
        end
    endtask

    task automatic test_normal_cycle();
        logic [11:0] pat [7];
        int          rep [7];
        pat[0] = {GRN, GRN, RED, RED}; rep[0] = 10;
        pat[1] = {GRN, YEL, RED, RED}; rep[1] = 2;
        pat[2] = {GRN, RED, GRN, RED}; rep[2] = 5;
        pat[3] = {YEL, RED, YEL, RED}; rep[3] = 2;
        pat[4] = {RED, RED, RED, GRN}; rep[4] = 5;
        pat[5] = {RED, RED, RED, YEL}; rep[5] = 2;
        pat[6] = ALL_RED;              rep[6] = 1;
        startup();
        for (int p = 0; p < 7; p++) begin
            for (int r = 0; r < rep[p]; r++) begin
                drive(pat[p]);
                tick();
                total++;
                if (safe_bus !== pat[p] || fault !== 1'b0) begin
                    bad++;
                    $display("FAIL normal[%0d.%0d]: safe=%h fault=%b want %h 0", p, r, safe_bus, fault, pat[p]);
                end
            end
        end
    endtask

    task automatic test_conflict();
        startup();
        drive({RED, GRN, GRN, RED});
        tick();
        total++;
        if (fault !== 1'b1 || fault_code !== 3'd2 || fault_src !== 4'b0110 || safe_bus !== ALL_RED) begin
            bad++;
            $display("FAIL conflict_detect: fault=%b code=%0d src=%b safe=%h want 1 2 0110 %h",
                     fault, fault_code, fault_src, safe_bus, ALL_RED);
        end
        // Illegal inputs during FAULT must not re-latch the code.
        drive({RED, RED, RED, 3'b111});
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (safe_bus !== ((i % 2 == 0) ? ALL_OFF : ALL_RED) || fault_code !== 3'd2 || fault_src !== 4'b0110) begin
                bad++;
                $display("FAIL flash[%0d]: safe=%h code=%0d src=%b want %h 2 0110", i, safe_bus, fault_code,
                         fault_src, (i % 2 == 0) ? ALL_OFF : ALL_RED);
            end
        end
    endtask

    task automatic test_sequencing();
        startup();
        drive({GRN, RED, RED, RED});
        tick();
        drive(ALL_RED);
        tick();
        total++;
        if (fault !== 1'b1 || fault_code !== 3'd3 || fault_src !== 4'b0001 || safe_bus !== ALL_RED) begin
            bad++;
            $display("FAIL transition: fault=%b code=%0d src=%b safe=%h want 1 3 0001 %h",
                     fault, fault_code, fault_src, safe_bus, ALL_RED);
        end
        startup();
        drive({RED, RED, RED, GRN});
        tick();
        drive({RED, RED, RED, YEL});
        tick();
        total++;
        if (safe_bus !== {RED, RED, RED, YEL} || fault !== 1'b0) begin
            bad++;
            $display("FAIL yellow_pass: safe=%h fault=%b want %h 0", safe_bus, fault, {RED, RED, RED, YEL});
        end
        drive(ALL_RED);
        tick();
        total++;
        if (fault !== 1'b1 || fault_code !== 3'd4 || fault_src !== 4'b1000 || safe_bus !== ALL_RED) begin
            bad++;
            $display("FAIL short_yellow: fault=%b code=%0d src=%b safe=%h want 1 4 1000 %h",
                     fault, fault_code, fault_src, safe_bus, ALL_RED);
        end
    endtask

    task automatic test_long_green();
        startup();
        drive({GRN, RED, RED, RED});
        for (int i = 1; i <= 60; i++) begin
            tick();
            total++;
            if (safe_bus !== {GRN, RED, RED, RED} || fault !== 1'b0) begin
                bad++;
                $display("FAIL green_hold[%0d]: safe=%h fault=%b want %h 0", i, safe_bus, fault, {GRN, RED, RED, RED});
            end
        end
        tick();
        total++;
        if (fault !== 1'b1 || fault_code !== 3'd5 || fault_src !== 4'b0001 || safe_bus !== ALL_RED) begin
            bad++;
            $display("FAIL long_green: fault=%b code=%0d src=%b safe=%h want 1 5 0001 %h",
                     fault, fault_code, fault_src, safe_bus, ALL_RED);
        end
    endtask

    task automatic test_priority();
        startup();
        drive({GRN, RED, RED, 3'b011});
        tick();
        total++;
        if (fault !== 1'b1 || fault_code !== 3'd1 || fault_src !== 4'b1000) begin
            bad++;
            $display("FAIL prio_illegal: fault=%b code=%0d src=%b want 1 1 1000", fault, fault_code, fault_src);
        end
        // M1 green->red (transition) together with an M2/S conflict: conflict wins, M1 not marked.
        startup();
        drive({GRN, RED, RED, RED});
        tick();
        drive({RED, GRN, RED, GRN});
        tick();
        total++;
        if (fault !== 1'b1 || fault_code !== 3'd2 || fault_src !== 4'b1010) begin
            bad++;
            $display("FAIL prio_conflict: fault=%b code=%0d src=%b want 1 2 1010", fault, fault_code, fault_src);
        end
    endtask

    task automatic test_clear();
        startup();
        drive({RED, RED, RED, GRN});
        tick();
        drive({GRN, RED, RED, GRN});
        tick();
        total++;
        if (fault !== 1'b1 || fault_code !== 3'd2 || fault_src !== 4'b1001) begin
            bad++;
            $display("FAIL clear_setup: fault=%b code=%0d src=%b want 1 2 1001", fault, fault_code, fault_src);
        end
        fault_clr = 1'b1;
        drive({RED, RED, RED, GRN});
        tick();
        total++;
        if (fault !== 1'b1 || fault_code !== 3'd2 || safe_bus !== ALL_OFF) begin
            bad++;
            $display("FAIL clear_ignored: fault=%b code=%0d safe=%h want 1 2 %h", fault, fault_code, safe_bus, ALL_OFF);
        end
        drive(ALL_RED);
        tick();
        total++;
        if (fault !== 1'b0 || fault_code !== 3'd0 || fault_src !== 4'd0 || safe_bus !== ALL_RED) begin
            bad++;
            $display("FAIL clear_apply: fault=%b code=%0d src=%b safe=%h want 0 0 0000 %h",
                     fault, fault_code, fault_src, safe_bus, ALL_RED);
        end
        fault_clr = 1'b0;
        drive({RED, GRN, RED, RED});
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (safe_bus !== ALL_RED) begin
                bad++;
                $display("FAIL clear_init[%0d]: safe=%h want %h", i, safe_bus, ALL_RED);
            end
        end
        tick();
        total++;
        if (safe_bus !== {RED, GRN, RED, RED} || fault !== 1'b0) begin
            bad++;
            $display("FAIL clear_run: safe=%h fault=%b want %h 0", safe_bus, fault, {RED, GRN, RED, RED});
        end
    endtask

    task automatic test_reset_in_fault();
        startup();
        drive({RED, GRN, GRN, RED});
        repeat (3) tick();
        total++;
        if (fault !== 1'b1 || safe_bus !== ALL_RED) begin
            bad++;
            $display("FAIL rif_flashing: fault=%b safe=%h want 1 %h", fault, safe_bus, ALL_RED);
        end
        drive({RED, GRN, RED, RED});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (safe_bus !== ALL_RED || fault !== 1'b0 || fault_code !== 3'd0 || fault_src !== 4'd0) begin
            bad++;
            $display("FAIL rif_reset: safe=%h fault=%b code=%0d src=%b want %h 0 0 0000",
                     safe_bus, fault, fault_code, fault_src, ALL_RED);
        end
        repeat (3) tick();
        tick();
        total++;
        if (safe_bus !== {RED, GRN, RED, RED} || fault !== 1'b0) begin
            bad++;
            $display("FAIL rif_restart: safe=%h fault=%b want %h 0", safe_bus, fault, {RED, GRN, RED, RED});
        end
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_conflict();
        test_sequencing();
        test_long_green();
        test_priority();
        test_clear();
        test_reset_in_fault();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
